// File: rtl/jesd204_ilas_pkg.sv
// Shared definitions for the JESD204 ILAS configuration block: octet map,
// field bit positions and the latched link configuration record.
package jesd204_ilas_pkg;

    localparam int ILAS_NUM_OCTETS   = 14;
    localparam int ILAS_PRE_OCTETS   = 13;
    localparam int ILAS_BLOCK_OCTETS = 16;

    localparam int OCT_DID     = 0;
    localparam int OCT_BID     = 1;
    localparam int OCT_LID     = 2;
    localparam int OCT_SCR_L   = 3;
    localparam int OCT_F       = 4;
    localparam int OCT_K       = 5;
    localparam int OCT_M       = 6;
    localparam int OCT_CS_N    = 7;
    localparam int OCT_SUBC_NP = 8;
    localparam int OCT_JESDV_S = 9;
    localparam int OCT_HD_CF   = 10;
    localparam int OCT_RES1    = 11;
    localparam int OCT_RES2    = 12;
    localparam int OCT_FCHK    = 13;

    localparam int SCR_BIT       = 7;
    localparam int CS_LSB        = 6;
    localparam int SUBCLASSV_LSB = 5;
    localparam int JESDV_LSB     = 5;
    localparam int HD_BIT        = 7;

    typedef struct packed {
        logic [7:0] did;
        logic [3:0] bid;
        logic       scr;
        logic [4:0] l_m1;
        logic [7:0] f_m1;
        logic [4:0] k_m1;
        logic [7:0] m_m1;
        logic [1:0] cs;
        logic [4:0] n_m1;
        logic [2:0] subclassv;
        logic [4:0] np_m1;
        logic [2:0] jesdv;
        logic [4:0] s_m1;
        logic       hd;
        logic [4:0] cf;
    } ilas_cfg_t;

    // Words per 16-octet block at a given beat width.
    function automatic int ILAS_WORDS(input int dpw);
        return ILAS_BLOCK_OCTETS / dpw;
    endfunction

endpackage

// File: rtl/jesd204_ilas_octet_pack.sv
// Packs the latched link configuration and one lane ID into the 13 octets
// that precede FCHK in the ILAS configuration block.
module jesd204_ilas_octet_pack
    import jesd204_ilas_pkg::*;
(
    input  ilas_cfg_t                         cfg_i,
    input  logic [4:0]                        lid_i,
    output logic [ILAS_PRE_OCTETS-1:0][7:0]   oct_o
);

    always_comb begin
        oct_o = '0;
        oct_o[OCT_DID]                          = cfg_i.did;
        oct_o[OCT_BID][3:0]                     = cfg_i.bid;
        oct_o[OCT_LID][4:0]                     = lid_i;
        oct_o[OCT_SCR_L][SCR_BIT]               = cfg_i.scr;
        oct_o[OCT_SCR_L][4:0]                   = cfg_i.l_m1;
        oct_o[OCT_F]                            = cfg_i.f_m1;
        oct_o[OCT_K][4:0]                       = cfg_i.k_m1;
        oct_o[OCT_M]                            = cfg_i.m_m1;
        oct_o[OCT_CS_N][CS_LSB+:2]              = cfg_i.cs;
        oct_o[OCT_CS_N][4:0]                    = cfg_i.n_m1;
        oct_o[OCT_SUBC_NP][SUBCLASSV_LSB+:3]    = cfg_i.subclassv;
        oct_o[OCT_SUBC_NP][4:0]                 = cfg_i.np_m1;
        oct_o[OCT_JESDV_S][JESDV_LSB+:3]        = cfg_i.jesdv;
        oct_o[OCT_JESDV_S][4:0]                 = cfg_i.s_m1;
        oct_o[OCT_HD_CF][HD_BIT]                = cfg_i.hd;
        oct_o[OCT_HD_CF][4:0]                   = cfg_i.cf;
    end

endmodule

// File: rtl/jesd204_tx_ilas_cfg_gen.sv
// TX ILAS configuration generator: latches link config, computes per-lane FCHK
// one lane per cycle, serves the block word-by-word. Optional FCHK error
// injection under JESD204_TX_ILAS_FCHK_INJECT_EN. DATA_PATH_WIDTH must be 4 or 8.
module jesd204_tx_ilas_cfg_gen
    import jesd204_ilas_pkg::*;
#(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   resetn,
`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
    input  logic                                   inject_fchk_err,
`endif
    input  logic                                   cfg_load,
    input  logic [7:0]                             cfg_did,
    input  logic [3:0]                             cfg_bid,
    input  logic [NUM_LANES*5-1:0]                 cfg_lids,
    input  logic                                   cfg_scr,
    input  logic [4:0]                             cfg_l_minus1,
    input  logic [7:0]                             cfg_f_minus1,
    input  logic [4:0]                             cfg_k_minus1,
    input  logic [7:0]                             cfg_m_minus1,
    input  logic [1:0]                             cfg_cs,
    input  logic [4:0]                             cfg_n_minus1,
    input  logic [2:0]                             cfg_subclassv,
    input  logic [4:0]                             cfg_np_minus1,
    input  logic [2:0]                             cfg_jesdv,
    input  logic [4:0]                             cfg_s_minus1,
    input  logic                                   cfg_hd,
    input  logic [4:0]                             cfg_cf,
    input  logic                                   ilas_config_rd,
    input  logic [1:0]                             ilas_config_addr,
    output logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] ilas_config_data,
    output logic                                   cfg_ready,
    output logic                                   status_rd_err
);

    localparam int         LCW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [1:0] WMASK     = 2'(ILAS_WORDS(DATA_PATH_WIDTH) - 1);
    localparam logic [1:0] FCHK_WORD = 2'(OCT_FCHK / DATA_PATH_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, READY} state_e;

    state_e                                        state_q, state_d;
    logic [LCW-1:0]                                lane_q, lane_d;
    ilas_cfg_t                                     cfg_q, cfg_d, cfg_in;
    logic [NUM_LANES-1:0][4:0]                     lids_q, lids_d;
    logic [NUM_LANES-1:0][7:0]                     fchk_q, fchk_d;
    logic [NUM_LANES-1:0][DATA_PATH_WIDTH-1:0][7:0] data_q, data_d, rd_word;
    logic                                          err_q, err_d;

    logic [NUM_LANES-1:0][ILAS_PRE_OCTETS-1:0][7:0]   lane_oct;
    logic [NUM_LANES-1:0][ILAS_BLOCK_OCTETS-1:0][7:0] blk;
    logic [7:0]                                    calc_sum;
    logic [1:0]                                    widx;
    logic                                          inj_flip;

    assign cfg_in = '{did: cfg_did, bid: cfg_bid, scr: cfg_scr, l_m1: cfg_l_minus1,
                      f_m1: cfg_f_minus1, k_m1: cfg_k_minus1, m_m1: cfg_m_minus1,
                      cs: cfg_cs, n_m1: cfg_n_minus1, subclassv: cfg_subclassv,
                      np_m1: cfg_np_minus1, jesdv: cfg_jesdv, s_m1: cfg_s_minus1,
                      hd: cfg_hd, cf: cfg_cf};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        jesd204_ilas_octet_pack u_pack (
            .cfg_i (cfg_q),
            .lid_i (lids_q[l]),
            .oct_o (lane_oct[l])
        );
    end

    // Single shared adder, stepped across lanes by lane_q during CALC.
    always_comb begin
        calc_sum = '0;
        for (int i = 0; i < ILAS_PRE_OCTETS; i++) calc_sum = calc_sum + lane_oct[lane_q][i];
    end

    assign widx = ilas_config_addr & WMASK;

`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
    logic armed_q, armed_d;
    assign inj_flip = armed_q && (widx == FCHK_WORD);

    always_comb begin
        armed_d = armed_q | inject_fchk_err;
        if (ilas_config_rd && state_q == READY && widx == FCHK_WORD) armed_d = inject_fchk_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) armed_q <= 1'b0;
        else         armed_q <= armed_d;
    end
`else
    assign inj_flip = 1'b0;
`endif

    always_comb begin
        blk = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int i = 0; i < ILAS_PRE_OCTETS; i++) blk[l][i] = lane_oct[l][i];
            blk[l][OCT_FCHK] = fchk_q[l];
        end
        blk[0][OCT_FCHK][0] = fchk_q[0][0] ^ inj_flip;
        for (int l = 0; l < NUM_LANES; l++)
            for (int o = 0; o < DATA_PATH_WIDTH; o++)
                rd_word[l][o] = blk[l][int'(widx)*DATA_PATH_WIDTH + o];
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cfg_d   = cfg_q;
        lids_d  = lids_q;
        fchk_d  = fchk_q;
        data_d  = data_q;
        err_d   = err_q;
        if (state_q == CALC) begin
            fchk_d[lane_q] = calc_sum;
            if (lane_q == LCW'(NUM_LANES - 1)) state_d = READY;
            else                               lane_d  = lane_q + 1'b1;
        end
        // A load in any state restarts the sweep from lane 0 with the new values.
        if (cfg_load) begin
            cfg_d   = cfg_in;
            lids_d  = cfg_lids;
            lane_d  = '0;
            state_d = CALC;
            err_d   = 1'b0;
        end
        if (ilas_config_rd) begin
            if (state_q == READY) begin
                data_d = rd_word;
            end else begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lane_q  <= '0;
            cfg_q   <= '0;
            lids_q  <= '0;
            fchk_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cfg_q   <= cfg_d;
            lids_q  <= lids_d;
            fchk_q  <= fchk_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign ilas_config_data = data_q;
    assign cfg_ready        = (state_q == READY);
    assign status_rd_err    = err_q;

endmodule

// File: tb/tb_jesd204_tx_ilas_cfg_gen.sv
// Bench for jesd204_tx_ilas_cfg_gen: two instances (4- and 8-octet beats, two
// lanes) driven in parallel and compared against an arithmetic ILAS model.
module tb_jesd204_tx_ilas_cfg_gen;

    localparam int NL = 2;

    logic clk = 1'b0;
    logic resetn;
    logic cfg_load, rd;
    logic [1:0] addr;
`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
    logic inj;
`endif
    logic [NL*32-1:0] data4;
    logic [NL*64-1:0] data8;
    logic rdy4, rdy8, err4, err8;

    int n_chk = 0;
    int n_err = 0;

    // Field order: did bid scr l f k m cs n sv np jv s hd cf lid0 lid1
    int c_in[17];
    int c_q[17];
    int c_max[17] = '{255, 15, 1, 31, 255, 31, 255, 3, 31, 7, 31, 7, 31, 1, 31, 31, 31};
    logic [63:0]  e4;
    logic [127:0] e8;
    bit err_m;

    always #5 clk = ~clk;

    jesd204_tx_ilas_cfg_gen #(.NUM_LANES(NL), .DATA_PATH_WIDTH(4)) u_dut4 (
        .clk(clk), .resetn(resetn),
`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
        .inject_fchk_err(inj),
`endif
        .cfg_load(cfg_load), .cfg_did(8'(c_in[0])), .cfg_bid(4'(c_in[1])),
        .cfg_lids({5'(c_in[16]), 5'(c_in[15])}), .cfg_scr(1'(c_in[2])),
        .cfg_l_minus1(5'(c_in[3])), .cfg_f_minus1(8'(c_in[4])), .cfg_k_minus1(5'(c_in[5])),
        .cfg_m_minus1(8'(c_in[6])), .cfg_cs(2'(c_in[7])), .cfg_n_minus1(5'(c_in[8])),
        .cfg_subclassv(3'(c_in[9])), .cfg_np_minus1(5'(c_in[10])), .cfg_jesdv(3'(c_in[11])),
        .cfg_s_minus1(5'(c_in[12])), .cfg_hd(1'(c_in[13])), .cfg_cf(5'(c_in[14])),
        .ilas_config_rd(rd), .ilas_config_addr(addr), .ilas_config_data(data4),
        .cfg_ready(rdy4), .status_rd_err(err4)
    );

    jesd204_tx_ilas_cfg_gen #(.NUM_LANES(NL), .DATA_PATH_WIDTH(8)) u_dut8 (
        .clk(clk), .resetn(resetn),
`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
        .inject_fchk_err(inj),
`endif
        .cfg_load(cfg_load), .cfg_did(8'(c_in[0])), .cfg_bid(4'(c_in[1])),
        .cfg_lids({5'(c_in[16]), 5'(c_in[15])}), .cfg_scr(1'(c_in[2])),
        .cfg_l_minus1(5'(c_in[3])), .cfg_f_minus1(8'(c_in[4])), .cfg_k_minus1(5'(c_in[5])),
        .cfg_m_minus1(8'(c_in[6])), .cfg_cs(2'(c_in[7])), .cfg_n_minus1(5'(c_in[8])),
        .cfg_subclassv(3'(c_in[9])), .cfg_np_minus1(5'(c_in[10])), .cfg_jesdv(3'(c_in[11])),
        .cfg_s_minus1(5'(c_in[12])), .cfg_hd(1'(c_in[13])), .cfg_cf(5'(c_in[14])),
        .ilas_config_rd(rd), .ilas_config_addr(addr), .ilas_config_data(data8),
        .cfg_ready(rdy8), .status_rd_err(err8)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pre-checksum octets straight from the octet map.
    function automatic int octet(input int lane, input int idx);
        case (idx)
            0:  return c_q[0];
            1:  return c_q[1];
            2:  return c_q[15 + lane];
            3:  return c_q[2] * 128 + c_q[3];
            4:  return c_q[4];
            5:  return c_q[5];
            6:  return c_q[6];
            7:  return c_q[7] * 64 + c_q[8];
            8:  return c_q[9] * 32 + c_q[10];
            9:  return c_q[11] * 32 + c_q[12];
            10: return c_q[13] * 128 + c_q[14];
            default: return 0;
        endcase
    endfunction

    function automatic int blk_octet(input int lane, input int idx);
        int s = 0;
        if (idx != 13) return octet(lane, idx);
        for (int i = 0; i < 13; i++) s += octet(lane, i);
        return s % 256;
    endfunction

    function automatic logic [63:0] exp_word(input int dpw, input int lane, input int a, input bit inj_x);
        logic [63:0] w = '0;
        int base = (a % (16 / dpw)) * dpw;
        for (int o = 0; o < dpw; o++) begin
            int b = blk_octet(lane, base + o);
            if (inj_x && lane == 0 && base + o == 13) b = b ^ 1;
            w = w | (64'(b & 255) << (8 * o));
        end
        return w;
    endfunction

    function automatic logic [63:0] exp_bus4(input int a, input bit inj_x);
        logic [63:0] w0 = exp_word(4, 0, a, inj_x);
        logic [63:0] w1 = exp_word(4, 1, a, inj_x);
        return {w1[31:0], w0[31:0]};
    endfunction

    function automatic logic [127:0] exp_bus8(input int a, input bit inj_x);
        return {exp_word(8, 1, a, inj_x), exp_word(8, 0, a, inj_x)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input bit exp);
        chk({tag, "_rdy4"}, 128'(rdy4), 128'(exp));
        chk({tag, "_rdy8"}, 128'(rdy8), 128'(exp));
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        c_q   = c_in;
        err_m = 1'b0;
        chk_ready("load", 1'b0);
        chk("load_err4", 128'(err4), 128'(0));
    endtask

    task automatic do_read(input int a, input bit rdy_x, input bit inj_x);
        rd   = 1'b1;
        addr = 2'(a);
        tick();
        rd = 1'b0;
        if (rdy_x) begin
            e4 = exp_bus4(a, inj_x);
            e8 = exp_bus8(a, inj_x);
        end else begin
            e4    = '0;
            e8    = '0;
            err_m = 1'b1;
        end
        chk("rd_data4", 128'(data4), 128'(e4));
        chk("rd_data8", data8, e8);
        chk("rd_err4", 128'(err4), 128'(err_m));
        chk("rd_err8", 128'(err8), 128'(err_m));
    endtask

    task automatic rand_cfg();
        for (int i = 0; i < 17; i++) c_in[i] = int'($urandom_range(0, c_max[i]));
    endtask

    initial begin
        resetn = 1'b0; cfg_load = 1'b0; rd = 1'b0; addr = '0;
`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
        inj = 1'b0;
`endif
        c_in = '{default: 0};
        c_q  = '{default: 0};
        err_m = 1'b0; e4 = '0; e8 = '0;
        tick(); tick();
        chk_ready("reset", 1'b0);
        chk("reset_data4", 128'(data4), 128'(0));
        chk("reset_data8", data8, 128'(0));
        chk("reset_err4", 128'(err4), 128'(0));
        resetn = 1'b1;
        tick();

        // Read before any load
        do_read(1, 1'b0, 1'b0);

        // Directed link configuration
        c_in = '{8'h5A, 3, 1, 3, 1, 31, 3, 0, 15, 1, 15, 1, 0, 0, 0, 0, 1};
        do_load();
        tick();
        chk_ready("calc1", 1'b0);
        tick();
        chk_ready("ready", 1'b1);
        do_read(0, 1'b1, 1'b0);
        chk("tp_word0", 128'(data4[31:0]), 128'(32'h8300_035A));
        do_read(3, 1'b1, 1'b0);
        chk("tp_fchk", 128'(data4), 128'(64'h0000_6200_0000_6100));
        chk("tp_dpw8", 128'(data8[63:0]), 128'(64'h0000_6100_0000_202F));
        tick();
        chk("hold_data4", 128'(data4), 128'(e4));
        chk("hold_data8", data8, e8);

`ifdef JESD204_TX_ILAS_FCHK_INJECT_EN
        inj = 1'b1;
        tick();
        inj = 1'b0;
        do_read(3, 1'b1, 1'b1);
        chk("inj_word", 128'(data4[31:0]), 128'(32'h0000_6000));
        do_read(3, 1'b1, 1'b0);
        chk("inj_once", 128'(data4[31:0]), 128'(32'h0000_6100));
`endif

        // Read and load in the same READY cycle: old config served
        c_in[0] = 8'h11;
        rd = 1'b1; addr = 2'd0; cfg_load = 1'b1;
        tick();
        rd = 1'b0; cfg_load = 1'b0;
        e4 = exp_bus4(0, 1'b0);
        e8 = exp_bus8(0, 1'b0);
        c_q = c_in;
        chk("rdld_data4", 128'(data4), 128'(e4));
        chk("rdld_data8", data8, e8);
        chk("rdld_err4", 128'(err4), 128'(0));
        chk_ready("rdld", 1'b0);

        // Load during CALC restarts the sweep
        c_in[0] = 0;
        do_load();
        tick();
        chk_ready("restart1", 1'b0);
        tick();
        chk_ready("restart2", 1'b1);
        do_read(3, 1'b1, 1'b0);
        chk("restart_fchk", 128'(data4[31:0]), 128'(32'h0000_0700));

        // Async reset mid-CALC
        do_load();
        #2 resetn = 1'b0;
        #1;
        chk_ready("midrst", 1'b0);
        chk("midrst_data4", 128'(data4), 128'(0));
        chk("midrst_err4", 128'(err4), 128'(0));
        c_q = '{default: 0}; err_m = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        tick();
        do_read(2, 1'b0, 1'b0);

        // Randomized configs and reads
        for (int it = 0; it < 30; it++) begin
            rand_cfg();
            do_load();
            if ($urandom_range(0, 3) == 0) do_read(int'($urandom_range(0, 3)), 1'b0, 1'b0);
            else tick();
            chk_ready("rnd_calc", 1'b0);
            tick();
            chk_ready("rnd_ready", 1'b1);
            rand_cfg();
            for (int k = 0; k < 3; k++) do_read(int'($urandom_range(0, 3)), 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk("rnd_hold4", 128'(data4), 128'(e4));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
